crypto_stage_seq: RTL

//  Single-clock sequencer for the cryptoveril stage pipeline. Accepts one job (data + key) over a valid/ready

---
 rtl/crypto_stage_seq.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/crypto_stage_seq.sv
// crypto_stage_seq: single-job sequencer for the two-stage crypto pipeline.
// Accepts a job over valid/ready, pulses stage-1 load and start, waits for the
// stage-1 and stage-2 done flags under an optional watchdog, then returns the
// captured result over valid/ready together with a job count and error flag.
module crypto_stage_seq #(
    parameter int DATA_W  = 16,
    parameter int KEY_W   = 5,
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [DATA_W-1:0] req_data,
    input  logic [KEY_W-1:0]  req_key,
    output logic [DATA_W-1:0] stg_data,
    output logic [KEY_W-1:0]  stg_key,
    output logic              stg_ld,
    output logic              stg_start,
    input  logic              stg1_done,
    input  logic              stg2_done,
    input  logic [DATA_W-1:0] res_in,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [DATA_W-1:0] res_data,
    output logic              busy,
    output logic              timeout_err,
    output logic [CNT_W-1:0]  job_cnt
);

    // Timer wide enough to hold TIMEOUT; at least one bit so the logic stays legal
    // when the watchdog is disabled.
    localparam int               TMR_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(TIMEOUT);
    localparam logic [TMR_W-1:0] TMR_ONE  = TMR_W'(32'd1);
    localparam logic [TMR_W-1:0] TMR_ZERO = TMR_W'(32'd0);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(32'd1);
    localparam bit               WDOG_EN  = (TIMEOUT != 0);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        START = 3'd2,
        WAIT1 = 3'd3,
        WAIT2 = 3'd4,
        OUT   = 3'd5,
        ERR   = 3'd6
    } state_t;

    state_t              state_q, state_d;
    logic [TMR_W-1:0]    timer_q, timer_d;
    logic [DATA_W-1:0]   stg_data_q, stg_data_d;
    logic [KEY_W-1:0]    stg_key_q, stg_key_d;
    logic [DATA_W-1:0]   res_data_q, res_data_d;
    logic [CNT_W-1:0]    job_cnt_q, job_cnt_d;
    logic                err_q, err_d;
    logic                req_ready_q;
    logic                busy_q;
    logic                ld_q;
    logic                start_q;
    logic                res_valid_q;

    // Next-state, datapath capture, watchdog and counter update.
    always_comb begin
        state_d    = state_q;
        timer_d    = timer_q;
        stg_data_d = stg_data_q;
        stg_key_d  = stg_key_q;
        res_data_d = res_data_q;
        job_cnt_d  = job_cnt_q;
        err_d      = err_q;
        case (state_q)
            IDLE: begin
                // req_ready is high throughout IDLE, so valid alone completes the handshake.
                if (req_valid) begin
                    stg_data_d = req_data;
                    stg_key_d  = req_key;
                    err_d      = 1'b0;
                    state_d    = LOAD;
                end else begin
                    state_d = IDLE;
                end
            end
            LOAD: begin
                state_d = START;
            end
            START: begin
                timer_d = TMR_LOAD;
                state_d = WAIT1;
            end
            WAIT1: begin
                // Done is checked first so a flag arriving on the last timer tick wins.
                if (stg1_done) begin
                    timer_d = TMR_LOAD;
                    state_d = WAIT2;
                end else if (WDOG_EN && (timer_q == TMR_ZERO)) begin
                    state_d = ERR;
                end else if (timer_q != TMR_ZERO) begin
                    timer_d = timer_q - TMR_ONE;
                end else begin
                    timer_d = timer_q;
                end
            end
            WAIT2: begin
                if (stg2_done) begin
                    res_data_d = res_in;
                    state_d    = OUT;
                end else if (WDOG_EN && (timer_q == TMR_ZERO)) begin
                    state_d = ERR;
                end else if (timer_q != TMR_ZERO) begin
                    timer_d = timer_q - TMR_ONE;
                end else begin
                    timer_d = timer_q;
                end
            end
            OUT: begin
                if (res_ready) begin
                    job_cnt_d = job_cnt_q + CNT_ONE;
                    state_d   = IDLE;
                end else begin
                    state_d = OUT;
                end
            end
            ERR: begin
                err_d   = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; handshake/pulse outputs are decoded from the
    // next state so they are registered yet line up with the state they describe.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            timer_q     <= TMR_ZERO;
            stg_data_q  <= {DATA_W{1'b0}};
            stg_key_q   <= {KEY_W{1'b0}};
            res_data_q  <= {DATA_W{1'b0}};
            job_cnt_q   <= {CNT_W{1'b0}};
            err_q       <= 1'b0;
            req_ready_q <= 1'b1;
            busy_q      <= 1'b0;
            ld_q        <= 1'b0;
            start_q     <= 1'b0;
            res_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            stg_data_q  <= stg_data_d;
            stg_key_q   <= stg_key_d;
            res_data_q  <= res_data_d;
            job_cnt_q   <= job_cnt_d;
            err_q       <= err_d;
            req_ready_q <= (state_d == IDLE);
            busy_q      <= (state_d != IDLE);
            ld_q        <= (state_d == LOAD);
            start_q     <= (state_d == START);
            res_valid_q <= (state_d == OUT);
        end
    end

    assign req_ready   = req_ready_q;
    assign busy        = busy_q;
    assign stg_ld      = ld_q;
    assign stg_start   = start_q;
    assign res_valid   = res_valid_q;
    assign stg_data    = stg_data_q;
    assign stg_key     = stg_key_q;
    assign res_data    = res_data_q;
    assign job_cnt     = job_cnt_q;
    assign timeout_err = err_q;

endmodule
